// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule (with subByte S-box word helper)
// Description : Iterative AES-128/192/256 key expander that produces one
//               schedule word per clock, with a registered round-key read port.
// Revision    : 1.0 - initial release
// ============================================================================

module subByte (
   input  logic [31:0] data,
   output logic [31:0] sub
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Inverse is a^254 (0 maps to 0), followed by the AES affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h01;
      for (int k = 7; k >= 0; k--) begin
         inv = gf_mul(inv, inv);
         if (k != 0) inv = gf_mul(inv, a);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   generate
      for (genvar g = 0; g < 4; g++) begin : g_sbox
         assign sub[8*g +: 8] = sbox(data[8*g +: 8]);
      end
   endgenerate
endmodule

module aes_key_schedule #(
   parameter int MAX_NK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         key_ready,
   output logic [3:0]   nr,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk,
   output logic         rk_valid
);
   localparam int         c_depth  = 4 * (MAX_NK + 7);
   localparam int         c_iw     = $clog2(c_depth);
   localparam logic [3:0] c_max_nk = 4'(MAX_NK);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_EXPAND = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [31:0]       r_w [0:c_depth-1];
   logic [255:0]      r_key;
   logic [3:0]        r_nk;
   logic [c_iw-1:0]   r_i;
   logic [c_iw-1:0]   r_last;
   logic [2:0]        r_p;
   logic [7:0]        r_rcon;

   logic [3:0]        w_req_nk;
   logic              w_mode_ok;
   logic              w_accept;
   logic              w_reject;
   logic              w_load;
   logic              w_expand;
   logic              w_fin;
   logic [31:0]       w_prev;
   logic [31:0]       w_back;
   logic [31:0]       w_sub_in;
   logic [31:0]       w_sub_out;
   logic [31:0]       w_t;
   logic [31:0]       w_new;
   logic              w_rd_ok;
   logic [c_iw-1:0]   w_base;

   always_comb begin
      case (key_len)
         2'd0:    w_req_nk = 4'd4;
         2'd1:    w_req_nk = 4'd6;
         2'd2:    w_req_nk = 4'd8;
         default: w_req_nk = 4'd0;
      endcase
   end

   assign w_mode_ok = (key_len != 2'd3) && (w_req_nk <= c_max_nk);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_load       = 1'b0;
      w_expand     = 1'b0;
      w_fin        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_mode_ok) begin
                  w_accept     = 1'b1;
                  w_next_state = S_LOAD;
               end else begin
                  w_reject     = 1'b1;
               end
            end
         end
         S_LOAD: begin
            w_load       = 1'b1;
            w_next_state = S_EXPAND;
         end
         S_EXPAND: begin
            w_expand = 1'b1;
            if (r_i == r_last) w_next_state = S_FIN;
         end
         S_FIN: begin
            w_fin        = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // Word recurrence: both substitution cases share the single S-box word.
   assign w_prev   = r_w[r_i - c_iw'(1)];
   assign w_back   = r_w[r_i - c_iw'(r_nk)];
   assign w_sub_in = (r_p == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   subByte u_sub (
      .data (w_sub_in),
      .sub  (w_sub_out)
   );

   always_comb begin
      w_t = w_prev;
      if (r_p == 3'd0)                          w_t = w_sub_out ^ {r_rcon, 24'h000000};
      else if (r_nk == 4'd8 && r_p == 3'd4)     w_t = w_sub_out;
   end

   assign w_new = w_back ^ w_t;

   always_ff @(posedge clk) begin
      if (w_load) begin
         for (int k = 0; k < 8; k++) begin
            if (k < int'(r_nk)) r_w[k] <= r_key[255-32*k -: 32];
         end
      end else if (w_expand) begin
         r_w[r_i] <= w_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key     <= '0;
         r_nk      <= 4'd0;
         r_i       <= '0;
         r_last    <= '0;
         r_p       <= 3'd0;
         r_rcon    <= 8'h01;
         done      <= 1'b0;
         err       <= 1'b0;
         key_ready <= 1'b0;
         nr        <= 4'd0;
      end else begin
         done <= w_fin;
         err  <= w_reject;
         if (w_accept) begin
            r_key     <= key;
            r_nk      <= w_req_nk;
            r_last    <= c_iw'({w_req_nk, 2'b00}) + c_iw'(27);
            key_ready <= 1'b0;
            nr        <= 4'd0;
         end
         if (w_load) begin
            r_i    <= c_iw'(r_nk);
            r_p    <= 3'd0;
            r_rcon <= 8'h01;
         end
         // p walks i mod Nk; Nk=8 wraps naturally through the 3-bit compare.
         if (w_expand) begin
            r_i <= r_i + c_iw'(1);
            r_p <= (r_p == 3'(r_nk - 4'd1)) ? 3'd0 : r_p + 3'd1;
            if (r_p == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
         end
         if (w_fin) begin
            key_ready <= 1'b1;
            nr        <= r_nk + 4'd6;
         end
      end
   end

   assign w_rd_ok = key_ready && (rk_idx <= nr);
   assign w_base  = c_iw'({rk_idx, 2'b00});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk       <= '0;
         rk_valid <= 1'b0;
      end else begin
         rk_valid <= w_rd_ok;
         rk       <= w_rd_ok ? {r_w[w_base], r_w[w_base + c_iw'(1)],
                                r_w[w_base + c_iw'(2)], r_w[w_base + c_iw'(3)]} : '0;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_schedule
// Description : Randomized self-checking bench for aes_key_schedule against a
//               FIPS-197 style key-expansion model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'd0;
   logic [255:0] key = '0;
   logic [3:0]   rk_idx = 4'd0;
   logic         busy, done, err, key_ready, rk_valid;
   logic [3:0]   nr;
   logic [127:0] rk;
   logic         busy4, done4, err4, key_ready4, rk_valid4;
   logic [3:0]   nr4;
   logic [127:0] rk4;

   int checks = 0;
   int errors = 0;
   logic [7:0] sbox [0:255];

   aes_key_schedule #(.MAX_NK(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
      .busy(busy), .done(done), .err(err), .key_ready(key_ready), .nr(nr),
      .rk_idx(rk_idx), .rk(rk), .rk_valid(rk_valid)
   );

   aes_key_schedule #(.MAX_NK(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
      .busy(busy4), .done(done4), .err(err4), .key_ready(key_ready4), .nr(nr4),
      .rk_idx(rk_idx), .rk(rk4), .rk_valid(rk_valid4)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [7:0] rcon(input int j);
      case (j)
         1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
         5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
         9: return 8'h1b; 10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic int nk_of(input logic [1:0] kl);
      return (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
   endfunction

   function automatic logic [1919:0] expand(input logic [255:0] k, input int nk);
      logic [31:0]   w [0:59];
      logic [31:0]   t;
      logic [1919:0] r;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = w[i-1];
         if (i % nk == 0)                t = subw({t[23:0], t[31:24]}) ^ {rcon(i/nk), 24'h0};
         else if (nk > 6 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      r = '0;
      for (int i = 0; i < 60; i++) r[i*32 +: 32] = w[i];
      return r;
   endfunction

   function automatic logic [127:0] rk_of(input logic [1919:0] s, input int j);
      return {s[(4*j)*32 +: 32], s[(4*j+1)*32 +: 32], s[(4*j+2)*32 +: 32], s[(4*j+3)*32 +: 32]};
   endfunction

   logic [1919:0] m_w = '0;
   logic [1919:0] m_pend = '0;
   logic [3:0]    m_pend_nr = 4'd0;
   logic [3:0]    m_nr = 4'd0;
   logic          m_ready = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rkv = 1'b0;
   logic [127:0]  m_rk = '0;
   int            m_left = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready <= 1'b0; m_nr <= 4'd0; m_left <= 0;
         m_done <= 1'b0; m_err <= 1'b0; m_rkv <= 1'b0; m_rk <= '0;
      end else begin
         if (m_ready && rk_idx <= m_nr) begin
            m_rkv <= 1'b1;
            m_rk  <= rk_of(m_w, int'(rk_idx));
         end else begin
            m_rkv <= 1'b0;
            m_rk  <= '0;
         end
         m_done <= 1'b0;
         m_err  <= 1'b0;
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_done  <= 1'b1;
               m_ready <= 1'b1;
               m_nr    <= m_pend_nr;
               m_w     <= m_pend;
            end
         end else if (start) begin
            if (key_len == 2'd3) begin
               m_err <= 1'b1;
            end else begin
               m_pend    <= expand(key, nk_of(key_len));
               m_pend_nr <= 4'(nk_of(key_len) + 6);
               m_left    <= 3 * nk_of(key_len) + 30;
               m_ready   <= 1'b0;
               m_nr      <= 4'd0;
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if ({busy, done, err, key_ready, nr, rk_valid, rk} !==
          {m_left != 0, m_done, m_err, m_ready, m_nr, m_rkv, m_rk}) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t actual busy%b done%b err%b rdy%b nr%0d v%b rk%h required busy%b done%b err%b rdy%b nr%0d v%b rk%h",
                  $time, busy, done, err, key_ready, nr, rk_valid, rk,
                  m_left != 0, m_done, m_err, m_ready, m_nr, m_rkv, m_rk);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   task automatic start_req(input logic [255:0] k, input logic [1:0] kl);
      @(negedge clk);
      start = 1'b1; key = k; key_len = kl;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lat, input bit noise);
      int n;
      n = 0;
      while (!done && n < 200) begin
         start  = 1'b0;
         rk_idx = 4'($urandom_range(0, 15));
         if (noise && n >= 1 && n < 30 && $urandom_range(0, 2) == 0) begin
            start   = 1'b1;
            key     = rand_key();
            key_len = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL done_timeout actual none required done within %0d cycles", lat);
      end else begin
         chk("start_to_done_latency", 256'(n), 256'(lat));
      end
   endtask

   task automatic run(input logic [255:0] k, input logic [1:0] kl, input int lat, input bit noise);
      start_req(k, kl);
      wait_done(lat, noise);
   endtask

   task automatic read(input string nm, input int idx, input logic v, input logic [127:0] r);
      rk_idx = 4'(idx);
      @(negedge clk);
      chk({nm, "_valid"}, 256'(rk_valid), 256'(v));
      chk(nm, 256'(rk), 256'(r));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual still running required finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] p, q, x;
      int lats [0:2];
      logic [1:0] kl;
      lats[0] = 42; lats[1] = 48; lats[2] = 54;

      p = 8'h01; q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'b0000};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;

      chk("model_aes128_r10", 256'(rk_of(expand(K128, 4), 10)), 256'(R128_10));
      chk("model_aes192_r12", 256'(rk_of(expand(K192, 6), 12)), 256'(R192_12));
      chk("model_aes256_r14", 256'(rk_of(expand(K256, 8), 14)), 256'(R256_14));

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 256'({busy, done, err, key_ready, nr, rk_valid, rk}), '0);
      rst_n = 1'b1;

      run(K128, 2'd0, 42, 1'b0);
      chk("aes128_nr", 256'(nr), 256'(10));
      read("aes128_rk10", 10, 1'b1, R128_10);
      read("aes128_rk0", 0, 1'b1, K128[255:128]);

      run(K192, 2'd1, 48, 1'b0);
      chk("aes192_nr", 256'(nr), 256'(12));
      read("aes192_rk12", 12, 1'b1, R192_12);
      read("aes192_rk13", 13, 1'b0, 128'h0);

      start_req(K256, 2'd2);
      chk("maxnk4_err", 256'(err4), 256'(1));
      chk("maxnk4_busy", 256'(busy4), 256'(0));
      wait_done(54, 1'b0);
      read("aes256_rk14", 14, 1'b1, R256_14);

      run(K128, 2'd0, 42, 1'b0);
      start_req(rand_key(), 2'd3);
      chk("reserved_err", 256'(err), 256'(1));
      chk("reserved_busy", 256'(busy), 256'(0));
      read("reserved_keeps_rk10", 10, 1'b1, R128_10);

      run(K256, 2'd2, 54, 1'b0);
      run(K128, 2'd0, 42, 1'b1);
      read("ignore_restart_rk10", 10, 1'b1, R128_10);

      start_req(K192, 2'd1);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset_busy", 256'(busy), 256'(0));
      chk("midrun_reset_ready", 256'(key_ready), 256'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("after_reset_idle", 256'({busy, key_ready, nr}), '0);
      run(K128, 2'd0, 42, 1'b0);
      read("after_reset_rk10", 10, 1'b1, R128_10);
      read("after_reset_rk0", 0, 1'b1, K128[255:128]);

      for (int it = 0; it < 12; it++) begin
         kl = 2'($urandom_range(0, 3));
         if (kl == 2'd3) begin
            start_req(rand_key(), kl);
            chk("rand_reserved_err", 256'(err), 256'(1));
         end else begin
            run(rand_key(), kl, lats[kl], it[0]);
         end
         for (int j = 0; j < 16; j++) begin
            rk_idx = 4'(j);
            @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
